// File: rtl/reg_arbiter_pkg.sv
// Shared types and constants for the two-requester register arbiter.
// Holds the FSM encoding, default width and write-count ceiling.
package reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam logic [7:0] WCNT_MAX = 8'hFF;

  // last=1 means requester 1 was served most recently
  function automatic state_t arbitrate(
    input logic req0,
    input logic req1,
    input logic last
  );
    state_t nxt;
    nxt = IDLE;
    unique case (1'b1)
      (req0 & req1):  nxt = last ? G0 : G1;
      (req0 & ~req1): nxt = G0;
      (~req0 & req1): nxt = G1;
      default:        nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/reg_arbiter_register.sv
// Enabled storage register with asynchronous active-low clear.
// Loads DATA on a rising edge while ENA is high, otherwise holds.
module reg_arbiter_register #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] R
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      R <= '0;
    end else if (ENA) begin
      R <= DATA;
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin write arbiter for one shared register, two requesters.
// A grant lasts one cycle and is always followed by an idle cycle.
module reg_arbiter
  import reg_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] DATA0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DATA1,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] R,
  output logic [7:0]       WCNT
);

  state_t           state;
  state_t           nxt;
  logic             last;
  logic [7:0]       wcnt;
  logic             ena;
  logic [WIDTH-1:0] din;

  assign nxt = arbitrate(REQ0, REQ1, last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      last  <= 1'b1;
      wcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= nxt;
          if (nxt == G0) last <= 1'b0;
          if (nxt == G1) last <= 1'b1;
        end
        G0, G1: begin
          state <= IDLE;
          if (wcnt != WCNT_MAX) wcnt <= wcnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants are single state bits, so they cannot glitch
  assign GNT0 = state[0];
  assign GNT1 = state[1];
  assign WCNT = wcnt;

  assign ena = (state == G0) || (state == G1);
  assign din = (state == G1) ? DATA1 : DATA0;

  reg_arbiter_register #(
    .WIDTH(WIDTH)
  ) register (
    .CLK  (CLK),
    .RST  (RST),
    .ENA  (ena),
    .DATA (din),
    .R    (R)
  );

endmodule

// File: tb/tb_reg_arbiter.sv
// Bench for reg_arbiter: vector table, directed corners, random traffic.
// A transaction-level model tracks who is granted and what R holds.
module tb_reg_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ0 = 1'b0;
  logic       REQ1 = 1'b0;
  logic [7:0] DATA0 = 8'h00;
  logic [7:0] DATA1 = 8'h00;
  logic       GNT0;
  logic       GNT1;
  logic [7:0] R;
  logic [7:0] WCNT;

  int n_cmp = 0;
  int n_bad = 0;

  reg_arbiter #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ0  (REQ0),
    .DATA0 (DATA0),
    .REQ1  (REQ1),
    .DATA1 (DATA1),
    .GNT0  (GNT0),
    .GNT1  (GNT1),
    .R     (R),
    .WCNT  (WCNT)
  );

  always #50 CLK = ~CLK;

  // Model: m_grant = requester holding the grant (-1 none)
  int         m_grant = -1;
  int         m_last  = 1;
  logic [7:0] m_r     = 8'h00;
  int         m_cnt   = 0;

  function automatic int pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    return 1;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_grant <= -1;
      m_last  <= 1;
      m_r     <= 8'h00;
      m_cnt   <= 0;
    end else if (m_grant != -1) begin
      m_r     <= (m_grant == 0) ? DATA0 : DATA1;
      m_cnt   <= (m_cnt < 255) ? m_cnt + 1 : 255;
      m_grant <= -1;
    end else if (REQ0 || REQ1) begin
      m_grant <= pick(REQ0, REQ1, m_last);
      m_last  <= pick(REQ0, REQ1, m_last);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".gnt0"}, int'(GNT0), int'(m_grant == 0));
    chk({tag, ".gnt1"}, int'(GNT1), int'(m_grant == 1));
    chk({tag, ".r"}, int'(R), int'(m_r));
    chk({tag, ".wcnt"}, int'(WCNT), m_cnt);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       g0;
    logic       g1;
    logic [7:0] r;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic r1,
    input logic [7:0] d0, input logic [7:0] d1,
    input logic g0, input logic g1,
    input logic [7:0] r, input logic [7:0] cnt
  );
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.r = r; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    // expected values hold after the edge that samples each row
    tbl[0]  = mk(1, 1, 8'h0F, 8'hF0, 1, 0, 8'h00, 8'd0);
    tbl[1]  = mk(1, 1, 8'h0F, 8'hF0, 0, 0, 8'h0F, 8'd1);
    tbl[2]  = mk(1, 1, 8'h0F, 8'hF0, 0, 1, 8'h0F, 8'd1);
    tbl[3]  = mk(1, 1, 8'h0F, 8'hF0, 0, 0, 8'hF0, 8'd2);
    tbl[4]  = mk(1, 1, 8'h0F, 8'hF0, 1, 0, 8'hF0, 8'd2);
    tbl[5]  = mk(1, 1, 8'h0F, 8'hF0, 0, 0, 8'h0F, 8'd3);
    tbl[6]  = mk(1, 1, 8'h0F, 8'hF0, 0, 1, 8'h0F, 8'd3);
    tbl[7]  = mk(0, 0, 8'h0F, 8'hF0, 0, 0, 8'hF0, 8'd4);
    tbl[8]  = mk(0, 0, 8'h55, 8'hAA, 0, 0, 8'hF0, 8'd4);
    tbl[9]  = mk(0, 0, 8'hAA, 8'h55, 0, 0, 8'hF0, 8'd4);
    tbl[10] = mk(1, 0, 8'h81, 8'h55, 1, 0, 8'hF0, 8'd4);
    tbl[11] = mk(0, 0, 8'h81, 8'h55, 0, 0, 8'h81, 8'd5);
    tbl[12] = mk(0, 1, 8'h00, 8'h3C, 0, 1, 8'h81, 8'd5);
    tbl[13] = mk(0, 1, 8'h00, 8'h3C, 0, 0, 8'h3C, 8'd6);
    tbl[14] = mk(0, 1, 8'h00, 8'h3C, 0, 1, 8'h3C, 8'd6);
    tbl[15] = mk(0, 0, 8'h00, 8'h3C, 0, 0, 8'h3C, 8'd7);

    // reset with a pending request must keep everything cleared
    #1;
    RST = 1'b0;
    REQ0 = 1'b1;
    DATA0 = 8'hAA;
    #1;
    chk("rst_async.r", int'(R), 0);
    chk("rst_async.gnt0", int'(GNT0), 0);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.gnt0", int'(GNT0), 0);
      chk("rst.gnt1", int'(GNT1), 0);
      chk("rst.r", int'(R), 0);
      chk("rst.wcnt", int'(WCNT), 0);
    end
    REQ0 = 1'b0;
    RST = 1'b1;

    for (int i = 0; i < 16; i++) begin
      REQ0 = tbl[i].r0;
      REQ1 = tbl[i].r1;
      DATA0 = tbl[i].d0;
      DATA1 = tbl[i].d1;
      step();
      chk($sformatf("vec%0d.gnt0", i), int'(GNT0), int'(tbl[i].g0));
      chk($sformatf("vec%0d.gnt1", i), int'(GNT1), int'(tbl[i].g1));
      chk($sformatf("vec%0d.r", i), int'(R), int'(tbl[i].r));
      chk($sformatf("vec%0d.wcnt", i), int'(WCNT), int'(tbl[i].cnt));
      chk_model($sformatf("vec%0d.model", i));
    end

    // mid-write reset: abort a G1 write of 3C
    REQ0 = 1'b0;
    REQ1 = 1'b1;
    DATA1 = 8'h3C;
    step();
    chk("mid.pre_gnt1", int'(GNT1), 1);
    #10;
    RST = 1'b0;
    #1;
    chk("mid.r", int'(R), 0);
    chk("mid.gnt1", int'(GNT1), 0);
    chk("mid.wcnt", int'(WCNT), 0);
    @(negedge CLK);
    step();
    chk("mid.hold_r", int'(R), 0);
    chk("mid.hold_gnt1", int'(GNT1), 0);
    RST = 1'b1;
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    DATA0 = 8'h12;
    step();
    chk("mid.first_gnt0", int'(GNT0), 1);
    chk("mid.first_gnt1", int'(GNT1), 0);
    chk_model("mid.model");
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    step();
    chk("mid.after_r", int'(R), 8'h12);

    // saturation: 300 back-to-back writes from requester 1
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    REQ1 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      DATA1 = 8'($urandom);
      step();
      chk_model("sat");
    end
    chk("sat.wcnt", int'(WCNT), 255);
    REQ1 = 1'b0;
    step();
    step();
    chk("sat.nowrap", int'(WCNT), 255);

    // random traffic with occasional asynchronous reset pulses
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 500; i++) begin
      REQ0 = 1'($urandom_range(0, 1));
      REQ1 = 1'($urandom_range(0, 1));
      DATA0 = 8'($urandom);
      DATA1 = 8'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        #10;
        RST = 1'b0;
        #1;
        chk_model("rnd.rst");
        #5;
        RST = 1'b1;
      end
      step();
      chk_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared register.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 REQ0  input  1  write request, requester 0.
REQ-005 DATA0  input  WIDTH  write data, requester 0; valid while REQ0 is high.
REQ-006 REQ1  input  1  write request, requester 1.
REQ-007 DATA1  input  WIDTH  write data, requester 1; valid while REQ1 is high.
REQ-008 GNT0  output  1  grant to requester 0; high for exactly one cycle per granted write.
REQ-009 GNT1  output  1  grant to requester 1; high for exactly one cycle per granted write.
REQ-010 R  output  WIDTH  current contents of the shared register.
REQ-011 WCNT  output  8  saturating count of completed writes.

Function
REQ-012 The FSM SHALL have three states: IDLE, G0, G1.
REQ-013 GNT0 SHALL be high iff the state is G0, and GNT1 iff the state is G1 (Moore outputs, glitch-free).
REQ-014 In IDLE, with REQ0=1 and REQ1=0, the next state SHALL be G0; with REQ0=0 and REQ1=1, G1; with neither, IDLE.
REQ-015 In IDLE with REQ0=REQ1=1, the grant SHALL go to the requester not served last (round-robin).
REQ-016 A 1-bit LAST flag SHALL record the most recently granted requester, updated on entry to G0/G1.
REQ-017 From G0 or G1 the next state SHALL always be IDLE, so at most one write occurs every two cycles.
REQ-018 Register enable SHALL be high in G0/G1 only; data mux SHALL select DATA0 in G0 and DATA1 in G1.
REQ-019 Latency: REQx sampled high at edge k in IDLE -> GNTx high during cycle k..k+1 -> R = DATAx after edge k+1.
REQ-020 A requester SHALL drop REQx in the cycle after its GNTx. REQx still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-021 R SHALL hold its value in all cycles without a grant, regardless of DATA0/DATA1 changes.
REQ-022 WCNT SHALL increment by 1 on each edge that leaves G0 or G1, and SHALL saturate at 255 with no wrap.
REQ-023 REQ changes during G0/G1 SHALL NOT affect the current write.

Reset
REQ-024 RST=0 SHALL immediately, independent of CLK, force: state IDLE, GNT0=GNT1=0, R=0, WCNT=0, LAST=1 (requester 0 wins the first contention).
REQ-025 RST asserted during G0/G1 SHALL abort the write; R SHALL read 0, not the requester's data.
REQ-026 After RST deasserts, the first rising edge SHALL evaluate requests as in IDLE.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, G0=2'b01, G1=2'b10), WIDTH default, and the WCNT saturation constant.
REQ-028 The storage SHALL be the existing 8-bit enabled register module, instantiated once as sub-module "register" with ports CLK, RST, ENA, DATA, R.
REQ-029 FSM, LAST flag, data mux and WCNT SHALL reside in reg_arbiter itself.

Verification (CLK period 100 ns)
REQ-030 Reset: RST=0 with REQ0=1, DATA0=8'hAA -> R=8'h00, GNT0=GNT1=0, WCNT=0 throughout reset.
REQ-031 Single write: REQ0=1, DATA0=8'h81 -> GNT0 high for exactly one cycle, R=8'h81 one edge later, WCNT=1.
REQ-032 Contention: REQ0=REQ1=1 held, DATA0=8'h0F, DATA1=8'hF0 -> grant order G0, G1, G0, G1 with an idle cycle between grants; R alternates 8'h0F and 8'hF0.
REQ-033 Hold: no requests while DATA0/DATA1 toggle (8'h55/8'hAA) -> R unchanged, GNT0=GNT1=0.
REQ-034 Mid-write reset: RST=0 asserted while in G1 with DATA1=8'h3C -> R=8'h00, state IDLE, the next contention is granted to requester 0.
REQ-035 Saturation: 300 back-to-back REQ1 writes -> WCNT stops at 255 and does not wrap.
